// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/EX/memory status into the hazard controller, pipeline-register controls out.
// HAZARD_PERF_CNT_EN adds the stall/flush performance counters.
interface pipeline_hazard_ctrl_if;
  logic [3:0]  id_rs, id_rt, ex_write_reg;
  logic        id_uses_rs, id_uses_rt, ex_mem_read;
  logic        br_taken, hlt_id, hlt_wb, mem_req, mem_ready;
  logic        pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en;
  logic        halted, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_write_reg,
           br_taken, hlt_id, hlt_wb, mem_req, mem_ready,
    input  pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, halted, mem_err
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles, flush_count
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_write_reg,
           br_taken, hlt_id, hlt_wb, mem_req, mem_ready,
    output pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, halted, mem_err
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash, memory wait, halt drain.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_count counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

  state_t          state, state_nxt, ret_st, ret_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic            mem_err_q, err_nxt;
  logic            lu, mem_stall, hold_all;
  logic            pc, fd, fdf, de, def, em, mw;

  assign lu = hz.ex_mem_read && (hz.ex_write_reg != 4'd0) &&
              ((hz.id_uses_rs && (hz.id_rs == hz.ex_write_reg)) ||
               (hz.id_uses_rt && (hz.id_rt == hz.ex_write_reg)));
  assign mem_stall = hz.mem_req && !hz.mem_ready;

  always_comb begin
    {pc, fd, de, em, mw} = 5'b11111;
    {fdf, def}           = 2'b00;
    hold_all  = 1'b0;
    state_nxt = state;
    ret_nxt   = ret_st;
    cnt_nxt   = cnt;
    err_nxt   = mem_err_q;
    case (state)
      RUN: begin
        if (mem_stall) begin
          hold_all  = 1'b1;
          state_nxt = MEMWAIT;
          ret_nxt   = RUN;
          cnt_nxt   = TO_W'(1);
        end else if (lu) begin
          // one bubble; the load leaves EX next cycle so decode proceeds
          pc  = 1'b0;
          fd  = 1'b0;
          def = 1'b1;
        end else if (hz.br_taken) begin
          fdf = 1'b1;
        end else if (hz.hlt_id) begin
          pc        = 1'b0;
          fdf       = 1'b1;
          state_nxt = DRAIN;
        end
      end
      MEMWAIT: begin
        if (hz.mem_ready) begin
          state_nxt = ret_st;
          cnt_nxt   = '0;
        end else begin
          hold_all = 1'b1;
          if (cnt == TO_W'(MEM_TIMEOUT)) begin
            err_nxt   = 1'b1;
            state_nxt = HALTED;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        // only NOPs sit in decode here, so load-use and branches are moot
        if (mem_stall) begin
          hold_all  = 1'b1;
          state_nxt = MEMWAIT;
          ret_nxt   = DRAIN;
          cnt_nxt   = TO_W'(1);
        end else begin
          pc  = 1'b0;
          fdf = 1'b1;
          if (hz.hlt_wb) state_nxt = HALTED;
        end
      end
      default: hold_all = 1'b1;
    endcase
    if (hold_all || !rst) begin
      {pc, fd, de, em, mw} = 5'b00000;
      {fdf, def}           = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      ret_st    <= RUN;
      cnt       <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_st    <= ret_nxt;
      cnt       <= cnt_nxt;
      mem_err_q <= err_nxt;
    end
  end

  assign hz.pc_en    = pc;
  assign hz.fd_en    = fd;
  assign hz.fd_flush = fdf;
  assign hz.de_en    = de;
  assign hz.de_flush = def;
  assign hz.em_en    = em;
  assign hz.mw_en    = mw;
  assign hz.halted   = (state == HALTED);
  assign hz.mem_err  = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q, flush_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc && (state != HALTED) && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if ((fdf || def) && (flush_q != 16'hFFFF))              flush_q <= flush_q + 16'd1;
    end
  end
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the write-enables and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. Handles four cases: load-use hazards, taken-branch squash, multi-cycle data-memory waits, and halt draining. Sits beside the decode stage; consumes decode and EX register addresses plus memory handshake status.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEMWAIT before a memory error is declared (1..255).
TO_W, 8, width of the memory-wait counter; must hold MEM_TIMEOUT.

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs  in  4  rs address of the instruction in decode
id_rt  in  4  rt address of the instruction in decode
id_uses_rs  in  1  decode instruction reads rs
id_uses_rt  in  1  decode instruction reads rt
ex_mem_read  in  1  instruction in EX is a load
ex_write_reg  in  4  destination register of the instruction in EX
br_taken  in  1  branch resolved taken in decode this cycle
hlt_id  in  1  HLT decoded this cycle
hlt_wb  in  1  HLT has reached writeback
mem_req  in  1  MEM stage is accessing data memory
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC write enable
fd_en  out  1  IF/ID enable
fd_flush  out  1  IF/ID loads a NOP
de_en  out  1  ID/EX enable
de_flush  out  1  ID/EX loads a bubble (all controls 0)
em_en  out  1  EX/MEM enable
mw_en  out  1  MEM/WB enable
halted  out  1  processor stopped
mem_err  out  1  sticky memory-timeout error

Behaviour:
- Reset is asynchronous, active-low on rst.
  - While rst=0: state=RUN, timeout counter=0, halted=0, mem_err=0, all *_en=0, all flushes=0.
- Outputs are combinational from state and inputs (Mealy); state, counter and sticky flags are registered.
- Load-use hazard (lu):
  - ex_mem_read=1 and ex_write_reg!=0, and
  - either (id_uses_rs and id_rs==ex_write_reg) or (id_uses_rt and id_rt==ex_write_reg).
  - Register 0 never causes a hazard.
- States: RUN, MEMWAIT, DRAIN, HALTED.
- RUN default: all enables 1, flushes 0.
  - Priority 1 — mem_req=1, mem_ready=0:
    - All enables 0, flushes 0.
    - Next state MEMWAIT; record return state RUN; counter<=1.
  - Priority 2 — lu:
    - pc_en=0, fd_en=0, de_en=1, de_flush=1, em_en=1, mw_en=1.
    - Exactly one bubble per hazard. The following cycle ex_mem_read is 0, so decode proceeds.
  - Priority 3 — br_taken:
    - fd_flush=1, everything else enabled.
  - Priority 4 — hlt_id:
    - pc_en=0, fd_flush=1. Next state DRAIN.
  - br_taken together with hlt_id: branch wins; HLT is squashed and state stays RUN.
  - lu together with br_taken: lu wins; the branch re-evaluates next cycle.
- MEMWAIT:
  - All enables 0, flushes 0.
  - On mem_ready=1: all enables 1 this cycle; go to the return state; counter<=0.
  - Otherwise counter increments. When counter==MEM_TIMEOUT and mem_ready=0: mem_err<=1, next state HALTED.
- DRAIN:
  - pc_en=0, fd_en=1, fd_flush=1; other enables 1.
  - The memory-wait rule applies as in RUN, with return state DRAIN.
  - lu and br_taken are ignored, because only NOPs are in decode.
  - On hlt_wb=1: next state HALTED.
- HALTED:
  - All enables 0, flushes 0, halted=1.
  - Exits only by reset. mem_err holds its value.
- Reset mid-MEMWAIT or mid-DRAIN returns to RUN immediately (asynchronous).

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles [15:0] and output flush_count [15:0].
  - stall_cycles counts every cycle with pc_en=0 while not HALTED.
  - flush_count counts cycles with fd_flush or de_flush asserted.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: the ports and counters are absent. Core behaviour is identical either way.

Test Plan:
- Load-use: ex_mem_read=1, ex_write_reg=3, id_rs=3, id_uses_rs=1 -> one cycle of pc_en=0, fd_en=0, de_flush=1; next cycle all enables 1.
- R0 exclusion: same as above with ex_write_reg=0, id_rs=0 -> no stall, all enables 1.
- Memory wait: mem_req=1, mem_ready low for 5 cycles then high -> 5 cycles with all enables 0, then one cycle all 1, state RUN, mem_err=0.
- Timeout: MEM_TIMEOUT=16, mem_ready held 0 -> mem_err=1 and halted=1 after 16 MEMWAIT cycles; sticky until rst=0.
- Halt drain: hlt_id pulse, hlt_wb asserted 3 cycles later -> pc_en=0 and fd_flush=1 for those cycles, then halted=1 and all enables 0.
- Priority and reset: br_taken=1 with lu true -> lu stall only. Then drop rst during DRAIN -> immediate RUN, halted=0.
